// File: rtl/periph_bus.sv
// periph_bus: memory-mapped reloadable timer, LED/switch ports and 8N1 UART on the core's data bus.
// Reads are combinational from current register state; writes and all state update on the rising edge.
module periph_bus #(
  parameter int CLK_DIV = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        irq_out,
  output logic [7:0]  led,
  input  logic [7:0]  switch_in,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [1:0]  dbg_tx_state,
  output logic [1:0]  dbg_rx_state
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

  // Bus handshake: mem_read/mem_write are the valid strobes of a single-cycle access and the
  // block is always ready, so there is no ready/stall signal; a strobe low means no access.
  logic       in_range;
  logic [3:0] reg_idx;
  logic       wr_th, wr_tl, wr_tcon, wr_led, wr_txd, wr_ucon, rd_rxd;
  logic       unused_addr_lsbs;

  assign in_range         = (addr[31:6] == 26'h100_0000);
  assign reg_idx          = addr[5:2];
  assign unused_addr_lsbs = ^addr[1:0];
  assign wr_th   = mem_write && in_range && (reg_idx == 4'd0);
  assign wr_tl   = mem_write && in_range && (reg_idx == 4'd1);
  assign wr_tcon = mem_write && in_range && (reg_idx == 4'd2);
  assign wr_led  = mem_write && in_range && (reg_idx == 4'd3);
  assign wr_txd  = mem_write && in_range && (reg_idx == 4'd6);
  assign wr_ucon = mem_write && in_range && (reg_idx == 4'd8);
  assign rd_rxd  = mem_read  && in_range && (reg_idx == 4'd7);

  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, sw_s1_q, sw_s2_q;

  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d, txd_q, txd_d;
  logic        tx_line_q, tx_line_d;

  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rxd_q, rxd_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_ready_q, rx_ready_d, rx_ovr_q, rx_ovr_d;
  logic        tx_busy;

  // A CPU write to TL or TCON suppresses that cycle's increment/reload and status update.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tcon_q[0] && !wr_tl && !wr_tcon) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (wr_th)   th_d   = wdata;
    if (wr_tl)   tl_d   = wdata;
    if (wr_tcon) tcon_d = wdata[2:0];
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    txd_d      = txd_q;
    case (tx_state_q)
      ST_IDLE: begin
        tx_line_d = 1'b1;
        if (wr_txd) begin
          txd_d      = wdata[7:0];
          tx_shift_d = wdata[7:0];
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = ST_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // A fresh byte landing in RXD overrides a same-cycle clear of rx_ready or rx_overrun.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rxd_d      = rxd_q;
    rx_ready_d = rx_ready_q;
    rx_ovr_d   = rx_ovr_q;
    if (rd_rxd) rx_ready_d = 1'b0;
    if (wr_ucon && !wdata[2]) rx_ovr_d = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          if (rx_s2_q) begin
            rxd_d      = rx_shift_q;
            rx_ready_d = 1'b1;
            if (rx_ready_q) rx_ovr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q       <= '0;
      tl_q       <= '0;
      tcon_q     <= '0;
      led_q      <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= '0;
      tx_line_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rxd_q      <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_ready_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      th_q       <= th_d;
      tl_q       <= tl_d;
      tcon_q     <= tcon_d;
      if (wr_led) led_q <= wdata[7:0];
      sw_s1_q    <= switch_in;
      sw_s2_q    <= sw_s1_q;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rxd_q      <= rxd_d;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_ready_q <= rx_ready_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign tx_busy = (tx_state_q != ST_IDLE);

  always_comb begin
    rdata = '0;
    if (mem_read && in_range) begin
      case (reg_idx)
        4'd0:    rdata = th_q;
        4'd1:    rdata = tl_q;
        4'd2:    rdata = {29'd0, tcon_q};
        4'd3:    rdata = {24'd0, led_q};
        4'd4:    rdata = {24'd0, sw_s2_q};
        4'd6:    rdata = {24'd0, txd_q};
        4'd7:    rdata = {24'd0, rxd_q};
        4'd8:    rdata = {29'd0, rx_ovr_q, rx_ready_q, tx_busy};
        default: rdata = '0;
      endcase
    end
  end

  assign irq_out      = tcon_q[1] & tcon_q[2];
  assign led          = led_q;
  assign uart_tx      = tx_line_q;
  assign dbg_tx_state = tx_state_q;
  assign dbg_rx_state = rx_state_q;

endmodule

// File: tb/tb_periph_bus.sv
// Testbench for periph_bus: register map vectors, timer overflow, UART TX/RX framing,
// overrun, framing error, glitch rejection and mid-frame reset.
module tb_periph_bus;
  localparam int CD = 16;
  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_TXD  = 32'h4000_0018;
  localparam logic [31:0] A_RXD  = 32'h4000_001C;
  localparam logic [31:0] A_UCON = 32'h4000_0020;
  localparam logic [31:0] A_NONE = 32'h4000_0024;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic        irq_out, uart_tx, uart_rx_w;
  logic        rx_drive = 1'b1, loopback = 1'b0;
  logic [7:0]  led, switch_in = 8'h5A;
  logic [1:0]  dbg_tx_state, dbg_rx_state;

  logic [31:0] exp_q[$];
  logic [7:0]  rx_exp_q[$];
  vec_t        vecs[$];
  int          n_cmp = 0, n_fail = 0, lat = 0;
  logic [9:0]  tx_frame;

  assign uart_rx_w = loopback ? uart_tx : rx_drive;

  periph_bus #(.CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .rdata(rdata),
    .irq_out(irq_out), .led(led), .switch_in(switch_in),
    .uart_rx(uart_rx_w), .uart_tx(uart_tx),
    .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic sb_check(input string name, input logic [31:0] act);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got %h, scoreboard had no expected value", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", name, act, e);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] e);
    exp_q.push_back(e);
    sb_check(name, act);
  endtask

  // Driver tasks start and end just after a falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_write = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] e);
    addr = a; mem_read = 1'b1; mem_write = 1'b0;
    exp_q.push_back(e);
    #2;
    sb_check(name, rdata);
    @(negedge clk);
    mem_read = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx_drive = 1'b0;
    repeat (CD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drive = d[i];
      repeat (CD) @(negedge clk);
    end
    rx_drive = stop_bit;
    repeat (CD) @(negedge clk);
    rx_drive = 1'b1;
    repeat (CD) @(negedge clk);
  endtask

  task automatic wait_rx_ready(input string name, input int budget, output int cycles);
    bit found;
    found = 1'b0;
    cycles = 0;
    addr = A_UCON; mem_read = 1'b1; mem_write = 1'b0;
    while (!found && cycles < budget) begin
      @(negedge clk);
      #2;
      cycles++;
      if (rdata[1]) found = 1'b1;
    end
    mem_read = 1'b0;
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: rx_ready got 0 after %0d cycles, expected 1", name, budget);
    end
    @(negedge clk);
  endtask

  initial begin
    vecs.push_back('{A_TH,   32'h0, 1'b0, 32'h0});
    vecs.push_back('{A_TL,   32'h0, 1'b0, 32'h0});
    vecs.push_back('{A_TCON, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{A_LED,  32'h0, 1'b0, 32'h0});
    vecs.push_back('{A_SW,   32'h0, 1'b0, 32'h5A});
    vecs.push_back('{A_TXD,  32'h0, 1'b0, 32'h0});
    vecs.push_back('{A_RXD,  32'h0, 1'b0, 32'h0});
    vecs.push_back('{A_UCON, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{32'h4000_0014, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{A_NONE, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{A_TH,   32'h1234_5678, 1'b1, 32'h1234_5678});
    vecs.push_back('{A_TL,   32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D});
    vecs.push_back('{A_LED,  32'h0000_01A5, 1'b1, 32'h0000_00A5});
    vecs.push_back('{A_TCON, 32'hFFFF_FFF2, 1'b1, 32'h0000_0002});
    vecs.push_back('{A_TCON, 32'h0000_0000, 1'b1, 32'h0000_0000});
    vecs.push_back('{A_SW,   32'h0000_00FF, 1'b1, 32'h0000_005A});
    vecs.push_back('{A_RXD,  32'h0000_0077, 1'b1, 32'h0000_0000});
    vecs.push_back('{A_UCON, 32'h0000_0007, 1'b1, 32'h0000_0000});
    vecs.push_back('{A_NONE, 32'h0000_1111, 1'b1, 32'h0000_0000});
    vecs.push_back('{32'h5000_000C, 32'h0000_0033, 1'b1, 32'h0000_0000});

    // Clock/reset
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_uart_tx", 32'(uart_tx), 32'd1);
    check_val("reset_irq", 32'(irq_out), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read($sformatf("vec%0d_%h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end
    check_val("led_port", 32'(led), 32'hA5);

    switch_in = 8'hC3;
    bus_read("switch_sync_old", A_SW, 32'h5A);
    repeat (2) @(negedge clk);
    bus_read("switch_sync_new", A_SW, 32'hC3);

    bus_write(A_TH, 32'hFFFF_FFF0);
    bus_write(A_TL, 32'hFFFF_FFFD);
    bus_write(A_TCON, 32'd3);
    bus_read("tl_e0", A_TL, 32'hFFFF_FFFD);
    bus_read("tl_e1", A_TL, 32'hFFFF_FFFE);
    check_val("irq_early", 32'(irq_out), 32'd0);
    bus_read("tl_e2", A_TL, 32'hFFFF_FFFF);
    check_val("irq_set", 32'(irq_out), 32'd1);
    bus_read("tl_reload", A_TL, 32'hFFFF_FFF0);
    bus_read("tl_count", A_TL, 32'hFFFF_FFF1);
    bus_read("tcon_status", A_TCON, 32'd7);
    bus_write(A_TCON, 32'd3);
    check_val("irq_clear", 32'(irq_out), 32'd0);
    bus_read("tcon_cleared", A_TCON, 32'd3);
    bus_write(A_TCON, 32'd0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'd3);
    bus_read("tl_pre_ovf", A_TL, 32'hFFFF_FFFE);
    bus_write(A_TL, 32'h0000_1234);
    bus_read("tl_write_wins", A_TL, 32'h0000_1234);
    check_val("irq_ovf_write", 32'(irq_out), 32'd0);
    bus_read("tcon_ovf_write", A_TCON, 32'd3);
    bus_write(A_TCON, 32'd0);

    // TX frame of 0xA5, checked mid-bit; a second write mid-frame must be dropped.
    tx_frame = {1'b1, 8'hA5, 1'b0};
    bus_write(A_TXD, 32'hA5);
    repeat (7) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check_val($sformatf("tx_bit%0d", k), 32'(uart_tx), 32'(tx_frame[k]));
      if (k < 9) begin
        if (k == 3) begin
          bus_write(A_TXD, 32'h3C);
          repeat (CD - 1) @(negedge clk);
        end else if (k == 5) begin
          bus_read("tx_busy_mid", A_UCON, 32'd1);
          repeat (CD - 1) @(negedge clk);
        end else begin
          repeat (CD) @(negedge clk);
        end
      end
    end
    repeat (8) @(negedge clk);
    bus_read("tx_busy_last", A_UCON, 32'd1);
    bus_read("tx_busy_done", A_UCON, 32'd0);
    check_val("tx_idle_line", 32'(uart_tx), 32'd1);
    bus_read("txd_kept", A_TXD, 32'hA5);

    loopback = 1'b1;
    rx_exp_q.push_back(8'h5A);
    bus_write(A_TXD, 32'h5A);
    wait_rx_ready("loop_ready", 400, lat);
    repeat (20) @(negedge clk);
    loopback = 1'b0;
    bus_read("loop_ucon", A_UCON, 32'd2);
    bus_read("loop_rxd", A_RXD, 32'(rx_exp_q.pop_front()));
    bus_read("loop_ucon_cleared", A_UCON, 32'd0);

    fork
      send_frame(8'h11, 1'b1);
      wait_rx_ready("rx1_ready", 400, lat);
    join
    n_cmp++;
    if (lat < 153 || lat > 155) begin
      n_fail++;
      $display("FAIL rx_latency: got %0d cycles, expected 153..155", lat);
    end
    rx_exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1);
    bus_read("overrun_ucon", A_UCON, 32'd6);
    bus_write(A_UCON, 32'd7);
    bus_read("overrun_w1_ignored", A_UCON, 32'd6);
    bus_read("overrun_rxd", A_RXD, 32'(rx_exp_q.pop_front()));
    bus_read("overrun_ready_clr", A_UCON, 32'd4);
    bus_write(A_UCON, 32'd0);
    bus_read("overrun_cleared", A_UCON, 32'd0);

    send_frame(8'h77, 1'b0);
    bus_read("framing_ucon", A_UCON, 32'd0);
    bus_read("framing_rxd", A_RXD, 32'h22);

    rx_drive = 1'b0;
    repeat (4) @(negedge clk);
    rx_drive = 1'b1;
    repeat (60) @(negedge clk);
    bus_read("glitch_ucon", A_UCON, 32'd0);
    check_val("glitch_rx_idle", 32'(dbg_rx_state), 32'd0);

    bus_write(A_TXD, 32'h00);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (50) @(negedge clk);
        check_val("tx_mid_low", 32'(uart_tx), 32'd0);
        check_val("rx_mid_data", 32'(dbg_rx_state), 32'd2);
        #3;
        reset = 1'b0;
        #1;
        check_val("rst_uart_tx", 32'(uart_tx), 32'd1);
        check_val("rst_tx_idle", 32'(dbg_tx_state), 32'd0);
        check_val("rst_rx_idle", 32'(dbg_rx_state), 32'd0);
        addr = A_UCON; mem_read = 1'b1;
        #1;
        check_val("rst_ucon", rdata, 32'd0);
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    bus_read("post_rst_ucon", A_UCON, 32'd0);
    bus_read("post_rst_rxd", A_RXD, 32'd0);

    rx_exp_q.push_back(8'hC3);
    fork
      send_frame(8'hC3, 1'b1);
      wait_rx_ready("final_ready", 400, lat);
    join
    bus_read("final_ucon", A_UCON, 32'd2);
    bus_read("final_rxd", A_RXD, 32'(rx_exp_q.pop_front()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus.md
# periph_bus

Memory-mapped peripheral block on the pipelined core's data bus, consuming the MEM-stage address/write-data/strobes and returning read data in the same cycle. Holds a reloadable 32-bit timer that raises the core's interrupt request, an LED register, a switch input port, and an 8N1 UART transmitter/receiver. Sits beside data RAM; the top-level decoder steers accesses with addr[31:28]==4'h4 here.

## Interface

- CLK_DIV, 16'd5208, clk cycles per UART bit (≥ 4)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low
- addr  input  32  MEM-stage byte address; bits [1:0] ignored
- wdata  input  32  store data
- mem_read  input  1  load strobe for this cycle
- mem_write  input  1  store strobe, committed at rising edge
- rdata  output  32  combinational read data; 0 when mem_read low or address unmapped
- irq_out  output  1  timer interrupt request (TCON[1] & TCON[2])
- led  output  8  LED register
- switch_in  input  8  raw switches, asynchronous
- uart_rx  input  1  serial in, asynchronous, idles high
- uart_tx  output  1  serial out, idles high

## Operation

- Map (word addresses): 0x40000000 TH (RW), 0x40000004 TL (RW), 0x40000008 TCON[2:0] (RW), 0x4000000C LED[7:0] (RW), 0x40000010 SWITCH[7:0] (RO), 0x40000018 TXD[7:0] (W; reads last written byte), 0x4000001C RXD[7:0] (RO), 0x40000020 UCON[2:0]. Other addresses: read 0, write ignored. Unused upper bits read 0.
- Reset values: TH=0, TL=0, TCON=0, LED=0, TXD=0, RXD=0, UCON=0, uart_tx=1, irq_out=0, both UART FSMs IDLE.
- Timer: TCON[0] enable, [1] interrupt enable, [2] status. While enabled, TL increments each cycle; when TL==32'hFFFF_FFFF, next cycle TL<=TH and, if TCON[1], TCON[2]<=1. Status cleared only by software write. CPU write to TL or TCON in the same cycle as increment/overflow wins (status not set that cycle).
- SWITCH: two-flop synchronizer; reads return synchronized value.
- UCON: [0] tx_busy (RO), [1] rx_ready (RO), [2] rx_overrun (write 0 clears; write 1 ignored).
- TX FSM IDLE->START->DATA->STOP->IDLE. Write to TXD in IDLE loads shifter, enters START; write while busy is dropped (TXD register unchanged). Each state bit lasts CLK_DIV cycles; data LSB first; 8 bits in DATA.
- RX FSM IDLE->START->DATA->STOP->IDLE, input through two-flop synchronizer. IDLE: on synchronized falling edge go START, count CLK_DIV/2; if line high then, return IDLE (glitch). Else sample 8 data bits every CLK_DIV cycles, LSB first, then stop bit. Stop=1: RXD<=byte, rx_ready<=1; if rx_ready already 1, also rx_overrun<=1. Stop=0 (framing error): byte discarded, flags unchanged. Return IDLE.
- Load (mem_read) of RXD clears rx_ready at that edge; simultaneous new-byte set wins.

## Timing

- Reads combinational: rdata valid same cycle as addr/mem_read; reflects register state before any same-edge write.
- Writes commit at the edge with mem_write=1; readback visible next cycle.
- Timer with TL=TH=0xFFFF_FFFE, enabled, interrupt enabled: TL=0xFFFF_FFFF after 1 cycle, reload and TCON[2]=1 after 2 cycles; irq_out combinational from TCON.
- TX: uart_tx falls at the edge after the TXD write; frame lasts exactly 10*CLK_DIV cycles; tx_busy high for exactly those cycles.
- RX: rx_ready rises 2 (sync) + CLK_DIV/2 + 9*CLK_DIV cycles ±1 after the rx falling edge.
- Reset asserted mid-frame: both FSMs return IDLE immediately, uart_tx=1, partial byte lost.

## Test plan

- Reset, then read all 9 addresses plus 0x40000024 -> all 0 except SWITCH = synchronized switch_in; uart_tx=1, irq_out=0.
- TH=0xFFFF_FFF0, TL=0xFFFF_FFFD, TCON=3 -> irq_out=1 three cycles later, TL=0xFFFF_FFF0 then counts; write TCON=3 -> irq_out=0; write TL on overflow cycle -> written value kept, status stays 0.
- CLK_DIV=16, write TXD=0xA5 -> uart_tx bits 0,1,0,1,0,0,1,0,1,1 each 16 cycles; second write of 0x3C mid-frame dropped; tx_busy low after 160 cycles.
- Loop uart_tx to uart_rx, send 0x5A -> RXD=0x5A, UCON=2; read RXD -> UCON=0 next cycle.
- Inject two frames without reading -> RXD=second byte, UCON[2]=1; frame with stop=0 -> RXD unchanged; 4-cycle low glitch -> no byte.
- Assert reset mid-TX and mid-RX -> uart_tx=1 immediately, UCON=0, next full frame received correctly.
